// File: rtl/isqrt_pipe.sv
// isqrt_pipe: fully pipelined integer square root with a valid/ready handshake.
// One root bit per stage (restoring digit recurrence), R = W/2 stages, one
// result per clock at full throughput. A single global stall freezes every
// rank while the output holds a result that downstream is not taking.
// Build option: define ISQRT_REM_EN to drive Rem from the final remainder.
// Without it, Rem is tied to 0 and the final remainder register is dropped.
module isqrt_pipe #(
  parameter  int W = 16,
  localparam int R = W / 2
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         In_valid,
  output logic         In_ready,
  input  logic [W-1:0] X,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic [R-1:0] Root,
  output logic [R:0]   Rem,
  output logic [W-1:0] X_out
);

  // Rank buses are sized for the widest remainder; each stage registers only
  // the bits its remainder can actually reach, the rest are constant zero.
  localparam int RW = R + 2;
  localparam int TW = RW + 3;

  logic          stall;
  logic          v_w    [0:R];
  logic [R-1:0]  root_w [0:R];
  logic [RW-1:0] rem_w  [0:R];
  logic [W-1:0]  x_w    [0:R];

  logic          in_v_q;
  logic [W-1:0]  in_x_q;

  assign stall    = v_w[R] & ~Out_ready;
  assign In_ready = ~stall;

  // Rank 0 captures the accepted radicand; its partial root and remainder are zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      in_v_q <= 1'b0;
      in_x_q <= '0;
    end else if (!stall) begin
      in_v_q <= In_valid & In_ready;
      in_x_q <= X;
    end
  end

  assign v_w[0]    = in_v_q;
  assign root_w[0] = '0;
  assign rem_w[0]  = '0;
  assign x_w[0]    = in_x_q;

  for (genvar s = 0; s < R; s++) begin : g_stage
    // After this stage the remainder is at most 2*root < 2^(s+2).
    localparam int SW = s + 2;

    logic [TW-1:0] shifted;
    logic [TW-1:0] trial;
    logic          ge;
    logic [R-1:0]  root_d;
    logic [SW-1:0] rem_d;
    logic          v_q;
    logic [R-1:0]  root_q;
    logic [W-1:0]  x_q;
    logic          unused_trial;

    // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
    always_comb begin
      shifted = TW'({rem_w[s], x_w[s][W-1-2*s -: 2]});
      trial   = shifted - TW'({root_w[s], 2'b01});
      ge      = ~trial[TW-1];
      root_d  = {root_w[s][R-2:0], ge};
      rem_d   = ge ? trial[SW-1:0] : shifted[SW-1:0];
    end

    // High trial bits are zero whenever the trial is kept; only the sign matters.
    assign unused_trial = ^trial[TW-2:SW];

    // Valid, root and radicand copy advance together unless the output stalls.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        v_q    <= 1'b0;
        root_q <= '0;
        x_q    <= '0;
      end else if (!stall) begin
        v_q    <= v_w[s];
        root_q <= root_d;
        x_q    <= x_w[s];
      end
    end

    assign v_w[s+1]    = v_q;
    assign root_w[s+1] = root_q;
    assign x_w[s+1]    = x_q;

    if (s < R - 1) begin : g_rem
      logic [SW-1:0] rem_q;

      // Intermediate remainder feeds the next stage's trial subtraction.
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          rem_q <= '0;
        end else if (!stall) begin
          rem_q <= rem_d;
        end
      end

      assign rem_w[s+1] = RW'(rem_q);
    end else begin : g_rem_last
`ifdef ISQRT_REM_EN
      logic [SW-1:0] rem_q;

      // Final remainder, X - Root^2, presented on Rem.
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          rem_q <= '0;
        end else if (!stall) begin
          rem_q <= rem_d;
        end
      end

      assign rem_w[s+1] = RW'(rem_q);
`else
      logic unused_rem;

      assign unused_rem = ^rem_d;
      assign rem_w[s+1] = '0;
`endif
    end
  end

  assign Out_valid = v_w[R];
  assign Root      = root_w[R];
  assign Rem       = rem_w[R][R:0];
  assign X_out     = x_w[R];

endmodule

// File: tb/tb_isqrt_pipe.sv
// Directed bench for isqrt_pipe: a W=16 instance for corners, bubbles,
// backpressure and mid-flight reset, and a W=8 instance for a full sweep.
module tb_isqrt_pipe;

`ifdef ISQRT_REM_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_x, a_x_out;
  logic [7:0]  a_root;
  logic [8:0]  a_rem;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_x, b_x_out;
  logic [3:0]  b_root;
  logic [4:0]  b_rem;

  isqrt_pipe #(.W(16)) u_dut16 (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(a_in_valid), .In_ready(a_in_ready),
    .X(a_x), .Out_valid(a_out_valid), .Out_ready(a_out_ready),
    .Root(a_root), .Rem(a_rem), .X_out(a_x_out)
  );

  isqrt_pipe #(.W(8)) u_dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(b_in_valid), .In_ready(b_in_ready),
    .X(b_x), .Out_valid(b_out_valid), .Out_ready(b_out_ready),
    .Root(b_root), .Rem(b_rem), .X_out(b_x_out)
  );

  int n_vec    = 0;
  int n_miscmp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int ref_root(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int ref_rem(input int x);
    int r;
    r = ref_root(x);
    return REM_EN ? (x - r * r) : 0;
  endfunction

  int c_x    [4] = '{0, 255, 256, 65535};
  int c_root [4] = '{0, 15, 16, 255};
  int c_rem  [4] = '{0, 30, 0, 510};

  int bb_x   [4] = '{100, 0, 0, 10000};
  int bb_rt  [4] = '{10, 0, 0, 100};
  logic [3:0] bb_pat;

  int xs [100];
  int sent, recv, exp_i, wait_n;
  bit exp_v, stall_prev;
  logic [7:0]  s_root;
  logic [8:0]  s_rem;
  logic [15:0] s_x;

  initial begin
    Rst_n = 1'b0;
    a_in_valid = 1'b0; a_x = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_x = '0; b_out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_root",      32'(a_root), 0);
    chk("rst_rem",       32'(a_rem), 0);
    chk("rst_x_out",     32'(a_x_out), 0);
    chk("rst_in_ready",  32'(a_in_ready), 1);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    // Corner values back-to-back, results 8 cycles after each accept.
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 13; cyc++) begin
      a_in_valid = (cyc < 4);
      if (cyc < 4) a_x = 16'(c_x[cyc]);
      else         a_x = '0;
      tick();
      exp_v = (cyc >= 8) && (cyc <= 11);
      chk("corner_valid", 32'(a_out_valid), 32'(exp_v));
      if (exp_v) begin
        chk("corner_root", 32'(a_root), c_root[cyc-8]);
        chk("corner_rem",  32'(a_rem), REM_EN ? c_rem[cyc-8] : 0);
        chk("corner_xout", 32'(a_x_out), c_x[cyc-8]);
      end
    end

    // Bubbles: valid pattern 1,0,0,1 reappears 8 cycles later.
    bb_pat = 4'b1001;
    for (int cyc = 0; cyc < 13; cyc++) begin
      a_in_valid = (cyc < 4) ? bb_pat[cyc] : 1'b0;
      a_x = (cyc < 4) ? 16'(bb_x[cyc]) : 16'h0;
      tick();
      exp_v = (cyc >= 8) && (cyc <= 11) && bb_pat[(cyc - 8) & 3];
      chk("bubble_valid", 32'(a_out_valid), 32'(exp_v));
      if (exp_v) chk("bubble_root", 32'(a_root), bb_rt[cyc-8]);
    end
    a_in_valid = 1'b0;

    // W=8 exhaustive sweep, continuous stream.
    b_out_ready = 1'b1;
    exp_i = 0;
    for (int cyc = 0; cyc < 268; cyc++) begin
      b_in_valid = (cyc < 256);
      b_x = 8'(cyc);
      tick();
      exp_v = (cyc >= 4) && (cyc < 260);
      chk("sweep_valid", 32'(b_out_valid), 32'(exp_v));
      if (b_out_valid) begin
        chk("sweep_xout", 32'(b_x_out), exp_i);
        chk("sweep_root", 32'(b_root), ref_root(exp_i));
        chk("sweep_rem",  32'(b_rem), ref_rem(exp_i));
        exp_i++;
      end
    end
    b_in_valid = 1'b0;
    chk("sweep_count", exp_i, 256);

    // Backpressure: random Out_ready, upstream holds X until accepted.
    for (int i = 0; i < 100; i++) xs[i] = int'($urandom_range(0, 65535));
    sent = 0; recv = 0; stall_prev = 1'b0;
    s_root = '0; s_rem = '0; s_x = '0;
    for (int cyc = 0; cyc < 3000 && recv < 100; cyc++) begin
      if (stall_prev) begin
        chk("bp_hold_valid", 32'(a_out_valid), 1);
        chk("bp_hold_root",  32'(a_root), 32'(s_root));
        chk("bp_hold_rem",   32'(a_rem), 32'(s_rem));
        chk("bp_hold_xout",  32'(a_x_out), 32'(s_x));
      end
      a_out_ready = 1'($urandom_range(0, 1));
      a_in_valid  = (sent < 100);
      a_x         = (sent < 100) ? 16'(xs[sent]) : 16'h0;
      #1;
      chk("bp_in_ready", 32'(a_in_ready), 32'(!(a_out_valid && !a_out_ready)));
      if (a_out_valid && a_out_ready) begin
        if (recv < 100) begin
          chk("bp_xout", 32'(a_x_out), xs[recv]);
          chk("bp_root", 32'(a_root), ref_root(xs[recv]));
          chk("bp_rem",  32'(a_rem), ref_rem(xs[recv]));
        end else begin
          chk("bp_extra", recv, 99);
        end
        recv++;
      end
      if (a_in_valid && a_in_ready) sent++;
      stall_prev = a_out_valid && !a_out_ready;
      s_root = a_root; s_rem = a_rem; s_x = a_x_out;
      tick();
    end
    a_in_valid = 1'b0;
    chk("bp_recv", recv, 100);
    chk("bp_sent", sent, 100);
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      chk("bp_no_dup", 32'(a_out_valid), 0);
    end

    // Reset mid-flight: 5 accepted, first one parked at the output.
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_x = 16'(1000 + 1111 * i);
      tick();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    wait_n = 0;
    while (!a_out_valid && wait_n < 20) begin
      tick();
      wait_n++;
    end
    chk("mf_filled",   32'(a_out_valid), 1);
    chk("mf_root_pre", 32'(a_root), 31);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("mf_out_valid", 32'(a_out_valid), 0);
    chk("mf_root",      32'(a_root), 0);
    chk("mf_rem",       32'(a_rem), 0);
    chk("mf_x_out",     32'(a_x_out), 0);
    chk("mf_in_ready",  32'(a_in_ready), 1);
    @(posedge Clk);
    #2;
    Rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      chk("mf_quiet", 32'(a_out_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
